bcd_display_counter: RTL and testbench

// - Next-generation 7-segment counter/decoder.
// - Parametrised N-digit BCD up/down counter with a count prescaler, wrap or saturate mode,

---
 rtl/bcd_seg_pkg.sv | 48 ++++
 rtl/bcd_digit.sv | 37 +++
 rtl/bcd_display_counter.sv | 108 ++++++++++
 tb/tb_bcd_display_counter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// Shared BCD width, active-low 7-segment glyphs ([0:7] = a..g,dp) and decode helpers.
// Latency: none, pure constants and combinational functions.
// Backpressure: not applicable.
package bcd_seg_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_t;
   // Index 0 is segment a, index 7 is dp; a 0 lights the segment.
   typedef logic [0:7] seg_t;

   localparam seg_t SEG_0     = 8'b0000_0011;
   localparam seg_t SEG_1     = 8'b1001_1111;
   localparam seg_t SEG_2     = 8'b0010_0101;
   localparam seg_t SEG_3     = 8'b0000_1101;
   localparam seg_t SEG_4     = 8'b1001_1001;
   localparam seg_t SEG_5     = 8'b0100_1001;
   localparam seg_t SEG_6     = 8'b0100_0001;
   localparam seg_t SEG_7     = 8'b0001_1111;
   localparam seg_t SEG_8     = 8'b0000_0001;
   localparam seg_t SEG_9     = 8'b0000_1001;
   localparam seg_t SEG_BLANK = 8'b1111_1111;

   // Glyph for one BCD digit; non-decimal codes show nothing rather than garbage.
   function automatic seg_t seg_decode(input bcd_t bcd);
      seg_t s;
      case (bcd)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Out-of-range load nibbles saturate at 9 so the counter never holds a non-BCD code.
   function automatic bcd_t bcd_clamp(input bcd_t v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD up/down digit with load; carry/borrow out ripples combinationally to the next digit.
// Latency: new value one clock after step or load; carry_out is same-cycle combinational.
// Backpressure: none, load overrides step.
module bcd_digit
   import bcd_seg_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic step,
   input  logic down,
   input  logic load,
   input  bcd_t load_val,
   output bcd_t q,
   output logic at_end,
   output logic carry_out
);

   // at_end: this digit is at the roll-over point for the current direction.
   assign at_end    = down ? (q == 4'd0) : (q == 4'd9);
   assign carry_out = step & at_end;

   // Digit register: load wins, otherwise step one place with 9<->0 roll-over.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= bcd_clamp(load_val);
      end else if (step) begin
         if (down) begin
            q <= at_end ? 4'd9 : q - 4'd1;
         end else begin
            q <= at_end ? 4'd0 : q + 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_display_counter.sv
// N-digit prescaled BCD up/down counter with wrap/saturate, load, terminal pulse and 7-seg scan.
// Latency: count/Carry one clock after the tick or load; Seg/Anode one clock after scan index change.
// Backpressure: none; En=0 freezes prescaler and count, scanning always runs.
module bcd_display_counter
   import bcd_seg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 4,
   parameter int SCAN_DIV = 2
)
(
   input  logic                    CLK,
   input  logic                    Reset,
   input  logic                    En,
   input  logic                    Type,
   input  logic                    Mode,
   input  logic                    Load,
   input  logic [BCD_W*DIGITS-1:0] LoadVal,
   output logic [BCD_W*DIGITS-1:0] Count,
   output logic                    Carry,
   output logic [0:7]              Seg,
   output logic [DIGITS-1:0]       Anode
);

   localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

   logic [PRE_W-1:0]  pre;
   logic [SCAN_W-1:0] scan_div;
   logic [IDX_W-1:0]  scan_idx;
   logic              tick;
   logic              terminal;
   logic              step;
   logic [DIGITS:0]   chain;
   logic [DIGITS-1:0] at_end;

   assign tick     = En & (pre == PRE_LAST);
   // Terminal count is every digit at its roll-over point (all 9s up, all 0s down).
   assign terminal = &at_end;
   // Saturate mode suppresses the step at terminal; load always pre-empts the tick.
   assign step     = tick & ~Load & ~(Mode & terminal);
   assign chain[0] = step;

   // Digit chain: each digit steps only when all lower digits roll over this cycle.
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk       (CLK),
         .rst       (Reset),
         .step      (chain[i]),
         .down      (Type),
         .load      (Load),
         .load_val  (LoadVal[i*BCD_W +: BCD_W]),
         .q         (Count[i*BCD_W +: BCD_W]),
         .at_end    (at_end[i]),
         .carry_out (chain[i+1])
      );
   end

   // Prescaler: runs only while enabled, restarts on tick and on load.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         pre <= '0;
      end else if (Load) begin
         pre <= '0;
      end else if (En) begin
         pre <= tick ? '0 : pre + PRE_W'(1);
      end
   end

   // Terminal-count pulse: in wrap mode the chain carry-out is exactly tick-at-terminal.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         Carry <= 1'b0;
      end else begin
         Carry <= Mode ? (tick & ~Load & terminal) : chain[DIGITS];
      end
   end

   // Scan timing: dwell SCAN_DIV clocks on each digit, independent of En.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         scan_div <= '0;
         scan_idx <= '0;
      end else if (scan_div == SCAN_LAST) begin
         scan_div <= '0;
         scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
      end else begin
         scan_div <= scan_div + SCAN_W'(1);
      end
   end

   // Display outputs registered together so anode and segments always match one digit.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         Anode <= '1;
         Seg   <= SEG_BLANK;
      end else begin
         Anode <= ~(DIGITS'(1) << scan_idx);
         Seg   <= seg_decode(Count[scan_idx*BCD_W +: BCD_W]);
      end
   end

endmodule

// File: tb/tb_bcd_display_counter.sv
// Self-checking bench: directed scenarios then randomized traffic against an integer reference model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_bcd_display_counter;

   localparam int D    = 4;
   localparam int P    = 4;
   localparam int S    = 2;
   localparam int MAXV = 9999;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        En = 1'b0;
   logic        Type = 1'b0;
   logic        Mode = 1'b0;
   logic        Load = 1'b0;
   logic [15:0] LoadVal = '0;
   logic [15:0] Count;
   logic        Carry;
   logic [0:7]  Seg;
   logic [3:0]  Anode;

   int tests = 0;
   int fails = 0;

   // Reference model state: count as a plain integer 0..9999.
   int         m_cnt, m_pre, m_sdiv, m_idx;
   logic       m_carry;
   logic [3:0] m_anode;
   logic [0:7] m_seg;

   bcd_display_counter #(.DIGITS(D), .PRESCALE(P), .SCAN_DIV(S)) dut (
      .CLK     (CLK),
      .Reset   (Reset),
      .En      (En),
      .Type    (Type),
      .Mode    (Mode),
      .Load    (Load),
      .LoadVal (LoadVal),
      .Count   (Count),
      .Carry   (Carry),
      .Seg     (Seg),
      .Anode   (Anode)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int x;
      x = v;
      for (int i = 0; i < D; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int load_value(input logic [15:0] lv);
      int v, w, nib;
      v = 0;
      w = 1;
      for (int i = 0; i < D; i++) begin
         nib = int'(lv[i*4 +: 4]);
         if (nib > 9) nib = 9;
         v = v + nib * w;
         w = w * 10;
      end
      return v;
   endfunction

   function automatic int digit_of(input int v, input int idx);
      int x;
      x = v;
      for (int i = 0; i < idx; i++) x = x / 10;
      return x % 10;
   endfunction

   // Glyph from the list of lit segment letters; lit segments are driven low.
   function automatic logic [0:7] glyph(input int d);
      string lit;
      logic [0:7] g;
      case (d)
         0: lit = "abcdef";
         1: lit = "bc";
         2: lit = "abdeg";
         3: lit = "abcdg";
         4: lit = "bcfg";
         5: lit = "acdfg";
         6: lit = "acdefg";
         7: lit = "abc";
         8: lit = "abcdefg";
         default: lit = "abcdfg";
      endcase
      g = 8'hFF;
      for (int k = 0; k < lit.len(); k++) g[int'(lit[k]) - 97] = 1'b0;
      return g;
   endfunction

   task automatic model_reset();
      m_cnt   = 0;
      m_pre   = 0;
      m_sdiv  = 0;
      m_idx   = 0;
      m_carry = 1'b0;
      m_anode = 4'hF;
      m_seg   = 8'hFF;
   endtask

   task automatic model_edge();
      m_seg   = glyph(digit_of(m_cnt, m_idx));
      m_anode = 4'hF;
      m_anode[m_idx] = 1'b0;
      m_carry = 1'b0;
      if (m_sdiv == S - 1) begin
         m_sdiv = 0;
         m_idx  = (m_idx + 1) % D;
      end else begin
         m_sdiv++;
      end
      if (Load) begin
         m_cnt = load_value(LoadVal);
         m_pre = 0;
      end else if (En) begin
         if (m_pre == P - 1) begin
            m_pre = 0;
            if (!Type) begin
               if (m_cnt == MAXV) begin
                  m_carry = 1'b1;
                  if (!Mode) m_cnt = 0;
               end else begin
                  m_cnt++;
               end
            end else begin
               if (m_cnt == 0) begin
                  m_carry = 1'b1;
                  if (!Mode) m_cnt = MAXV;
               end else begin
                  m_cnt--;
               end
            end
         end else begin
            m_pre++;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".count"}, {16'b0, Count}, {16'b0, to_bcd(m_cnt)});
      chk({tag, ".carry"}, {31'b0, Carry}, {31'b0, m_carry});
      chk({tag, ".anode"}, {28'b0, Anode}, {28'b0, m_anode});
      chk({tag, ".seg"},   {24'b0, Seg},   {24'b0, m_seg});
   endtask

   task automatic tick_clk(input string tag);
      @(posedge CLK);
      if (Reset) model_reset();
      else model_edge();
      #1;
      check_model(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset(input string tag);
      #2 Reset = 1'b1;
      #1;
      model_reset();
      chk({tag, ".count"}, {16'b0, Count}, 32'h0);
      chk({tag, ".carry"}, {31'b0, Carry}, 32'h0);
      chk({tag, ".anode"}, {28'b0, Anode}, 32'hF);
      chk({tag, ".seg"},   {24'b0, Seg},   32'hFF);
      #2 Reset = 1'b0;
   endtask

   initial begin
      int r;
      model_reset();

      // 1: reset held for 3 clocks with En=1, then release.
      En = 1'b1;
      for (int k = 0; k < 3; k++) tick_clk("t1_rst");
      chk("t1_count", {16'b0, Count}, 32'h0);
      chk("t1_carry", {31'b0, Carry}, 32'h0);
      chk("t1_anode", {28'b0, Anode}, 32'hF);
      chk("t1_seg",   {24'b0, Seg},   32'hFF);
      Reset = 1'b0;
      tick_clk("t1_first");
      chk("t1_first_anode", {28'b0, Anode}, 32'hE);
      chk("t1_first_seg",   {24'b0, Seg},   32'h03);

      // 2: up-count wrap from 9999.
      Type = 1'b0; Mode = 1'b0; LoadVal = 16'h9999; Load = 1'b1;
      tick_clk("t2_load");
      Load = 1'b0;
      chk("t2_loaded", {16'b0, Count}, 32'h9999);
      for (int k = 1; k <= 5; k++) begin
         tick_clk("t2_run");
         chk("t2_carry", {31'b0, Carry}, (k == 4) ? 32'h1 : 32'h0);
         chk("t2_count", {16'b0, Count}, (k >= 4) ? 32'h0 : 32'h9999);
      end

      // 3: down-count saturate at 0000.
      Type = 1'b1; Mode = 1'b1; LoadVal = 16'h0000; Load = 1'b1;
      tick_clk("t3_load");
      Load = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick_clk("t3_run");
         chk("t3_count", {16'b0, Count}, 32'h0);
         chk("t3_carry", {31'b0, Carry}, (k % 4 == 0) ? 32'h1 : 32'h0);
      end

      // 4: borrow ripple 1000 -> 0999, then freeze mid-prescale.
      Mode = 1'b0; LoadVal = 16'h1000; Load = 1'b1;
      tick_clk("t4_load");
      Load = 1'b0;
      for (int k = 0; k < 4; k++) tick_clk("t4_run");
      chk("t4_borrow", {16'b0, Count}, 32'h0999);
      tick_clk("t4_pre1");
      tick_clk("t4_pre2");
      En = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick_clk("t4_frozen");
         chk("t4_frozen_count", {16'b0, Count}, 32'h0999);
      end
      En = 1'b1;
      tick_clk("t4_resume1");
      chk("t4_resume1_count", {16'b0, Count}, 32'h0999);
      tick_clk("t4_resume2");
      chk("t4_resume2_count", {16'b0, Count}, 32'h0998);

      // 5: load with clamping coincident with a tick.
      Type = 1'b0;
      for (int k = 0; k < 8 && m_pre != P - 1; k++) tick_clk("t5_align");
      LoadVal = 16'hA5F3; Load = 1'b1;
      tick_clk("t5_load");
      Load = 1'b0;
      chk("t5_clamped", {16'b0, Count}, 32'h9593);
      chk("t5_carry",   {31'b0, Carry}, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         tick_clk("t5_run");
         chk("t5_step", {16'b0, Count}, (k == 4) ? 32'h9594 : 32'h9593);
      end

      // 6: asynchronous reset mid-count.
      tick_clk("t6_run");
      tick_clk("t6_run");
      async_reset("t6_async");
      tick_clk("t6_after");
      chk("t6_after_anode", {28'b0, Anode}, 32'hE);

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         En = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) Type = 1'($urandom);
         if ($urandom_range(0, 15) == 0) Mode = 1'($urandom);
         Load = ($urandom_range(0, 19) == 0);
         r = $urandom_range(0, 3);
         case (r)
            0: LoadVal = 16'h9999;
            1: LoadVal = 16'h0000;
            2: LoadVal = 16'($urandom);
            default: LoadVal = to_bcd($urandom_range(0, MAXV));
         endcase
         tick_clk("rnd");
         if ($urandom_range(0, 199) == 0) async_reset("rnd_async");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
